// File: rtl/bit_scatter_256_pkg.sv
// bit_scatter_256_pkg: shared widths and FSM state type for the bit scatter block
package bit_scatter_256_pkg;
    localparam int DEF_DATA_WIDTH = 256;
    localparam int DEF_SEL_WIDTH  = 8;
    localparam int CNT_WIDTH      = DEF_SEL_WIDTH + 1;
    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;
endpackage

// File: rtl/bit_scatter_256_decoder.sv
// decoder8x256: combinational binary-to-one-hot decoder
module decoder8x256 #(
    parameter int DATA_WIDTH = 256,
    parameter int SEL_WIDTH  = 8
) (
    input  logic [SEL_WIDTH-1:0]  sel,
    output logic [DATA_WIDTH-1:0] onehot
);
    assign onehot = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << sel;
endmodule

// File: rtl/bit_scatter_256.sv
// bit_scatter_256: streams single bits into addressed positions of a frame register
module bit_scatter_256
    import bit_scatter_256_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SEL_WIDTH  = DEF_SEL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_bit,
    input  logic [SEL_WIDTH-1:0]  in_addr,
    input  logic                  in_auto,
    input  logic                  in_last,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic [SEL_WIDTH:0]    bit_count
);
    localparam int CW = SEL_WIDTH + 1;
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] y_q, y_d, onehot, we;
    logic [SEL_WIDTH-1:0]  wr_ptr_q, wr_ptr_d, addr;
    logic [CW-1:0]         bit_count_q, bit_count_d;
    logic                  accept, handoff, restart;

    assign in_ready  = state_q == FILL;
    assign y_valid   = state_q == HOLD;
    assign y         = y_q;
    assign bit_count = bit_count_q;

    assign addr = in_auto ? wr_ptr_q : in_addr;

    decoder8x256 #(.DATA_WIDTH(DATA_WIDTH), .SEL_WIDTH(SEL_WIDTH)) u_dec (
        .sel    (addr),
        .onehot (onehot)
    );

    always_comb begin
        accept      = in_valid && in_ready && !clear;
        handoff     = y_valid && y_ready;
        restart     = clear || handoff;
        we          = onehot & {DATA_WIDTH{accept}};
        y_d         = restart ? '0 : (y_q & ~we) | (we & {DATA_WIDTH{in_bit}});
        bit_count_d = restart ? '0 : bit_count_q + CW'(accept);
        wr_ptr_d    = restart ? '0 : wr_ptr_q + SEL_WIDTH'(accept && in_auto);
        state_d     = state_q;
        if (clear)
            state_d = FILL;
        else if (state_q == FILL)
            // the 256th write closes the frame even without in_last
            state_d = (accept && (in_last || bit_count_q == CW'(DATA_WIDTH - 1))) ? HOLD : FILL;
        else
            state_d = y_ready ? FILL : HOLD;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            y_q         <= '0;
            wr_ptr_q    <= '0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            wr_ptr_q    <= wr_ptr_d;
            bit_count_q <= bit_count_d;
        end
    end
endmodule

// File: tb/tb_bit_scatter_256.sv
// tb_bit_scatter_256: directed self-checking bench for bit_scatter_256
module tb_bit_scatter_256;
    import bit_scatter_256_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n, in_valid, in_ready, in_bit, in_auto, in_last, clear;
    logic                 y_valid, y_ready;
    logic [7:0]           in_addr;
    logic [255:0]         y;
    logic [CNT_WIDTH-1:0] bit_count;
    int                   vectors = 0;
    int                   miscompares = 0;

    always #5 clk = ~clk;

    bit_scatter_256 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_addr   (in_addr),
        .in_auto   (in_auto),
        .in_last   (in_last),
        .clear     (clear),
        .y         (y),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .bit_count (bit_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic b, input logic [7:0] a, input logic auto, input logic last);
        in_valid = 1'b1;
        in_bit   = b;
        in_addr  = a;
        in_auto  = auto;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_ready();
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        vectors++;
        if (y !== '0 || y_valid !== 1'b0 || in_ready !== 1'b1 || bit_count !== 9'd0) begin
            miscompares++;
            $display("FAIL reset got y=%h yv=%b rdy=%b cnt=%0d want 0 0 1 0", y, y_valid, in_ready, bit_count);
        end
    endtask

    task automatic test_auto_fill();
        logic [255:0] exp;
        exp = {128{2'b10}};
        for (int i = 0; i < 255; i++) wr(i[0], 8'd0, 1'b1, 1'b0);
        vectors++;
        if (y_valid !== 1'b0 || bit_count !== 9'd255 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_255 got yv=%b cnt=%0d rdy=%b want 0 255 1", y_valid, bit_count, in_ready);
        end
        wr(1'b1, 8'd0, 1'b1, 1'b0);
        vectors++;
        if (y !== exp) begin
            miscompares++;
            $display("FAIL fill_y got %h want %h", y, exp);
        end
        vectors++;
        if (y_valid !== 1'b1 || bit_count !== 9'd256 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_done got yv=%b cnt=%0d rdy=%b want 1 256 0", y_valid, bit_count, in_ready);
        end
    endtask

    task automatic test_handoff();
        logic [255:0] exp;
        exp = {128{2'b10}};
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            in_auto  = 1'b1;
            tick();
            in_valid = 1'b0;
            vectors++;
            if (y !== exp || y_valid !== 1'b1 || bit_count !== 9'd256) begin
                miscompares++;
                $display("FAIL hold_%0d got yv=%b cnt=%0d y=%h want 1 256 %h", i, y_valid, bit_count, y, exp);
            end
        end
        in_valid = 1'b1;
        in_bit   = 1'b1;
        y_ready  = 1'b1;
        tick();
        y_ready  = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (y !== '0 || bit_count !== 9'd0 || in_ready !== 1'b1 || y_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL handoff got y=%h cnt=%0d rdy=%b yv=%b want 0 0 1 0", y, bit_count, in_ready, y_valid);
        end
    endtask

    task automatic test_explicit();
        logic [255:0] exp;
        exp = '0;
        exp[0] = 1'b1; exp[17] = 1'b1; exp[255] = 1'b1;
        wr(1'b1, 8'd0, 1'b0, 1'b0);
        wr(1'b1, 8'd17, 1'b0, 1'b0);
        wr(1'b1, 8'd255, 1'b0, 1'b1);
        vectors++;
        if (y !== exp || y_valid !== 1'b1 || bit_count !== 9'd3) begin
            miscompares++;
            $display("FAIL explicit got y=%h yv=%b cnt=%0d want %h 1 3", y, y_valid, bit_count, exp);
        end
        pulse_ready();
    endtask

    task automatic test_mixed();
        wr(1'b1, 8'd9, 1'b1, 1'b0);
        wr(1'b0, 8'd0, 1'b0, 1'b0);
        wr(1'b1, 8'd9, 1'b1, 1'b1);
        vectors++;
        if (y !== 256'h2 || bit_count !== 9'd3 || y_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mixed got y=%h cnt=%0d yv=%b want 2 3 1", y, bit_count, y_valid);
        end
        pulse_ready();
    endtask

    task automatic test_clear();
        wr(1'b1, 8'd3, 1'b0, 1'b0);
        clear = 1'b1;
        wr(1'b1, 8'd5, 1'b0, 1'b0);
        clear = 1'b0;
        vectors++;
        if (y !== '0 || bit_count !== 9'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_fill got y=%h cnt=%0d rdy=%b want 0 0 1", y, bit_count, in_ready);
        end
        wr(1'b1, 8'd7, 1'b0, 1'b1);
        vectors++;
        if (y_valid !== 1'b1 || y !== 256'h80) begin
            miscompares++;
            $display("FAIL clear_pre got yv=%b y=%h want 1 80", y_valid, y);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        vectors++;
        if (y_valid !== 1'b0 || in_ready !== 1'b1 || y !== '0 || bit_count !== 9'd0) begin
            miscompares++;
            $display("FAIL clear_hold got yv=%b rdy=%b y=%h cnt=%0d want 0 1 0 0", y_valid, in_ready, y, bit_count);
        end
    endtask

    task automatic test_midframe_reset();
        for (int i = 0; i < 100; i++) wr(1'b1, 8'd0, 1'b1, 1'b0);
        vectors++;
        if (bit_count !== 9'd100) begin
            miscompares++;
            $display("FAIL pre_reset_cnt got %0d want 100", bit_count);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if (y !== '0 || bit_count !== 9'd0 || in_ready !== 1'b1 || y_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset got y=%h cnt=%0d rdy=%b yv=%b want 0 0 1 0", y, bit_count, in_ready, y_valid);
        end
        wr(1'b1, 8'd50, 1'b1, 1'b1);
        vectors++;
        if (y !== 256'h1 || bit_count !== 9'd1) begin
            miscompares++;
            $display("FAIL post_reset_wr got y=%h cnt=%0d want 1 1", y, bit_count);
        end
        pulse_ready();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 256; i++) wr(1'b1, 8'd0, 1'b1, i == 255);
        vectors++;
        if (y !== {256{1'b1}} || y_valid !== 1'b1 || bit_count !== 9'd256) begin
            miscompares++;
            $display("FAIL b2b_full got y=%h yv=%b cnt=%0d want all-ones 1 256", y, y_valid, bit_count);
        end
        pulse_ready();
        tick();
        tick();
        vectors++;
        if (y_valid !== 1'b0 || in_ready !== 1'b1 || bit_count !== 9'd0) begin
            miscompares++;
            $display("FAIL b2b_single got yv=%b rdy=%b cnt=%0d want 0 1 0", y_valid, in_ready, bit_count);
        end
        wr(1'b1, 8'd0, 1'b1, 1'b1);
        vectors++;
        if (y !== 256'h1) begin
            miscompares++;
            $display("FAIL b2b_ptr_wrap got y=%h want 1", y);
        end
        pulse_ready();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_addr = '0;
        in_auto = 1'b0; in_last = 1'b0; clear = 1'b0; y_ready = 1'b0;
        #1;
        test_reset();
        test_auto_fill();
        test_handoff();
        test_explicit();
        test_mixed();
        test_clear();
        test_midframe_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
